// File: rtl/debounce_multi.sv
// debounce_multi: per-channel synchroniser, stability counter and debounced
// level for CH push buttons. It also produces one-cycle press, release and
// long-press event pulses. All outputs are registered.
module debounce_multi #(
   parameter int CH          = 4,
   parameter int DB_CYCLES   = 1024,
   parameter int LONG_CYCLES = 500000,
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CH-1:0] button_in,
   output logic [CH-1:0] DB_out,
   output logic [CH-1:0] press_pulse,
   output logic [CH-1:0] release_pulse,
   output logic [CH-1:0] long_pulse,
   output logic          any_active
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam int LW = $clog2(LONG_CYCLES + 1);

   localparam logic [CW-1:0] DB_MAX   = CW'(DB_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);
   localparam logic [LW-1:0] LONG_PRE = LW'(LONG_CYCLES - 1);
   localparam logic [LW-1:0] LCNT_ONE = LW'(1);

   logic [CH-1:0] pin_norm;
   logic [CH-1:0] sync1;
   logic [CH-1:0] sync2;
   logic [CH-1:0] stable;
   logic [CH-1:0] change;
   logic [CH-1:0] db_next;
   logic [CH-1:0] press_next;
   logic [CH-1:0] release_next;
   logic [CH-1:0] long_next;
   logic [CW-1:0] cnt  [CH];
   logic [LW-1:0] lcnt [CH];

   // Normalise so that 1 always means "pressed" downstream.
   assign pin_norm = ACTIVE_HIGH ? button_in : ~button_in;

   // Decide per channel whether the debounced level flips this edge.
   // A flip also requires the synchroniser pair to still agree at the
   // deciding edge. Without that check, a pin pulse one cycle shorter
   // than the minimum width could slip through on a saturated counter.
   // A release that lands on the saturating edge of the long counter
   // suppresses the long pulse.
   always_comb begin
      stable       = '0;
      change       = '0;
      long_next    = '0;
      for (int i = 0; i < CH; i++) begin
         stable[i] = (sync1[i] == sync2[i]);
         change[i] = stable[i] && (cnt[i] == DB_MAX) && (sync2[i] != DB_out[i]);
      end
      db_next      = DB_out ^ change;
      press_next   = change & sync2;
      release_next = change & ~sync2;
      for (int i = 0; i < CH; i++) begin
         long_next[i] = DB_out[i] && (lcnt[i] == LONG_PRE) && !release_next[i];
      end
   end

   // Two-flop synchroniser plus saturating stability and long-press counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         for (int i = 0; i < CH; i++) begin
            cnt[i]  <= '0;
            lcnt[i] <= '0;
         end
      end else begin
         sync1 <= pin_norm;
         sync2 <= sync1;
         for (int i = 0; i < CH; i++) begin
            if (!stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] < DB_MAX) begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
            if (!DB_out[i]) begin
               lcnt[i] <= '0;
            end else if (lcnt[i] < LONG_MAX) begin
               lcnt[i] <= lcnt[i] + LCNT_ONE;
            end
         end
      end
   end

   // Register the debounced levels, the event pulses and the activity flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         DB_out        <= '0;
         press_pulse   <= '0;
         release_pulse <= '0;
         long_pulse    <= '0;
         any_active    <= 1'b0;
      end else begin
         DB_out        <= db_next;
         press_pulse   <= press_next;
         release_pulse <= release_next;
         long_pulse    <= long_next;
         any_active    <= |db_next;
      end
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed testbench for debounce_multi with CH=4, DB_CYCLES=8,
// LONG_CYCLES=20 and ACTIVE_HIGH=0 (pins idle high, pressed low).
module tb_debounce_multi;

   localparam int CH = 4;

   logic          clk;
   logic          reset;
   logic [CH-1:0] button_in;
   logic [CH-1:0] DB_out;
   logic [CH-1:0] press_pulse;
   logic [CH-1:0] release_pulse;
   logic [CH-1:0] long_pulse;
   logic          any_active;

   int checks;
   int passed;
   int press_cnt   [CH];
   int release_cnt [CH];
   int long_cnt    [CH];

   debounce_multi #(
      .CH(CH),
      .DB_CYCLES(8),
      .LONG_CYCLES(20),
      .ACTIVE_HIGH(1'b0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .button_in(button_in),
      .DB_out(DB_out),
      .press_pulse(press_pulse),
      .release_pulse(release_pulse),
      .long_pulse(long_pulse),
      .any_active(any_active)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed === expected) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Press (1) or release (0) one channel; pins are active-low.
   task automatic applyStimulus(input int ch, input bit pressed);
      button_in[ch] = ~pressed;
   endtask

   // Advance n clock edges, sampling 1 time unit after each edge and
   // tallying every event pulse seen.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         for (int c = 0; c < CH; c++) begin
            if (press_pulse[c])   press_cnt[c]++;
            if (release_pulse[c]) release_cnt[c]++;
            if (long_pulse[c])    long_cnt[c]++;
         end
      end
   endtask

   task automatic clearCounts();
      for (int c = 0; c < CH; c++) begin
         press_cnt[c]   = 0;
         release_cnt[c] = 0;
         long_cnt[c]    = 0;
      end
   endtask

   function automatic int totalEvents();
      int sum;
      sum = 0;
      for (int c = 0; c < CH; c++) sum += press_cnt[c] + release_cnt[c] + long_cnt[c];
      return sum;
   endfunction

   initial begin
      checks    = 0;
      passed    = 0;
      reset     = 1'b1;
      button_in = '1;
      clearCounts();

      // Reset and idle-high pins: nothing happens.
      tick(2);
      reset = 1'b0;
      checkOutput("reset_db", 32'(DB_out), 32'h0);
      checkOutput("reset_any", 32'(any_active), 32'h0);
      clearCounts();
      tick(100);
      checkOutput("idle_events", 32'(totalEvents()), 32'd0);
      checkOutput("idle_db", 32'(DB_out), 32'h0);

      // Clean press and release on ch0, held 30 cycles.
      clearCounts();
      applyStimulus(0, 1'b1);
      tick(10);
      checkOutput("press0_early", 32'(DB_out), 32'h0);
      tick(1);
      checkOutput("press0_pulse", 32'(press_pulse), 32'h1);
      checkOutput("press0_db", 32'(DB_out), 32'h1);
      checkOutput("press0_any", 32'(any_active), 32'h1);
      tick(1);
      checkOutput("press0_one_cycle", 32'(press_pulse), 32'h0);
      tick(18);
      applyStimulus(0, 1'b0);
      tick(10);
      checkOutput("release0_early", 32'(DB_out), 32'h1);
      checkOutput("hold0_long", 32'(long_cnt[0]), 32'd1);
      tick(1);
      checkOutput("release0_pulse", 32'(release_pulse), 32'h1);
      checkOutput("release0_db", 32'(DB_out), 32'h0);
      tick(5);
      checkOutput("release0_count", 32'(release_cnt[0]), 32'd1);
      checkOutput("press0_count", 32'(press_cnt[0]), 32'd1);

      // Bounce on ch1: toggles every 3 cycles, last level pressed.
      clearCounts();
      for (int j = 0; j < 13; j++) begin
         applyStimulus(1, (j % 2) == 0);
         tick(3);
      end
      checkOutput("bounce_quiet", 32'(totalEvents()), 32'd0);
      tick(7);
      checkOutput("bounce_settle_early", 32'(press_pulse), 32'h0);
      tick(1);
      checkOutput("bounce_settle_press", 32'(press_pulse), 32'h2);
      applyStimulus(1, 1'b0);
      tick(12);
      checkOutput("bounce_release", 32'(release_cnt[1]), 32'd1);

      // Pin pulse one cycle too short is rejected.
      clearCounts();
      applyStimulus(1, 1'b1);
      tick(9);
      applyStimulus(1, 1'b0);
      tick(20);
      checkOutput("short9_events", 32'(totalEvents()), 32'd0);
      checkOutput("short9_db", 32'(DB_out), 32'h0);

      // Minimum-width pin pulse is accepted.
      clearCounts();
      applyStimulus(1, 1'b1);
      tick(10);
      applyStimulus(1, 1'b0);
      tick(1);
      checkOutput("min10_press", 32'(press_pulse), 32'h2);
      tick(20);
      checkOutput("min10_release", 32'(release_cnt[1]), 32'd1);

      // Long press on ch2.
      clearCounts();
      applyStimulus(2, 1'b1);
      tick(11);
      checkOutput("long_press_pulse", 32'(press_pulse), 32'h4);
      tick(19);
      checkOutput("long_early", 32'(long_pulse), 32'h0);
      tick(1);
      checkOutput("long_pulse", 32'(long_pulse), 32'h4);
      tick(1);
      checkOutput("long_one_cycle", 32'(long_pulse), 32'h0);
      tick(29);
      checkOutput("long_once", 32'(long_cnt[2]), 32'd1);
      applyStimulus(2, 1'b0);
      tick(15);
      checkOutput("long_released", 32'(DB_out), 32'h0);

      // Release lands on the saturating edge: release wins.
      clearCounts();
      applyStimulus(2, 1'b1);
      tick(20);
      applyStimulus(2, 1'b0);
      tick(11);
      checkOutput("cancel_release", 32'(release_pulse), 32'h4);
      checkOutput("cancel_nolong", 32'(long_pulse), 32'h0);
      tick(5);
      checkOutput("cancel_long_count", 32'(long_cnt[2]), 32'd0);

      // Simultaneous press on ch0 and ch3.
      clearCounts();
      applyStimulus(0, 1'b1);
      applyStimulus(3, 1'b1);
      tick(11);
      checkOutput("simul_press", 32'(press_pulse), 32'h9);
      checkOutput("simul_any", 32'(any_active), 32'h1);
      checkOutput("simul_db", 32'(DB_out), 32'h9);
      applyStimulus(0, 1'b0);
      applyStimulus(3, 1'b0);
      tick(11);
      checkOutput("simul_release", 32'(release_pulse), 32'h9);
      checkOutput("simul_any_off", 32'(any_active), 32'h0);

      // Reset while ch2 is debounced-pressed.
      clearCounts();
      applyStimulus(2, 1'b1);
      tick(14);
      checkOutput("midreset_pressed", 32'(DB_out), 32'h4);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      checkOutput("midreset_db", 32'(DB_out), 32'h0);
      checkOutput("midreset_norelease", 32'(release_pulse), 32'h0);
      checkOutput("midreset_any", 32'(any_active), 32'h0);
      tick(10);
      checkOutput("midreset_wait", 32'(DB_out), 32'h0);
      checkOutput("midreset_release_count", 32'(release_cnt[2]), 32'd0);
      tick(1);
      checkOutput("midreset_repress", 32'(press_pulse), 32'h4);
      applyStimulus(2, 1'b0);
      tick(15);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel push-button conditioner, the successor of the single-channel debouncer. Each of CH raw inputs gets its own two-flop synchroniser, a stability counter and a debounced level. Per-channel one-cycle press, release and long-press event pulses are also produced. It sits between board pins and the control FSMs, which consume events instead of edge-detecting levels themselves.

## Interface
- CH, 4: number of independent channels (1..32).
- DB_CYCLES, 1024: consecutive stable synchronised cycles required before the debounced level may change (>=2).
- LONG_CYCLES, 500000: cycles the debounced level must stay active before long_pulse fires (>=2).
- ACTIVE_HIGH, 1: 1 = pressed when pin is high; 0 = pressed when pin is low (the pin is inverted at entry).
- clk  input  1  single clock, all state on posedge.
- reset  input  1  synchronous, active-high; clears all state on the next posedge.
- button_in  input  CH  raw asynchronous button pins.
- DB_out  output  CH  debounced pressed level per channel (1 = pressed, regardless of ACTIVE_HIGH).
- press_pulse  output  CH  one-cycle pulse when DB_out goes 0->1.
- release_pulse  output  CH  one-cycle pulse when DB_out goes 1->0.
- long_pulse  output  CH  one-cycle pulse, once per press, after LONG_CYCLES of continuous DB_out=1.
- any_active  output  1  OR-reduction of DB_out (registered view of DB_out, same cycle).

## Operation
- Normalise: x[i] = ACTIVE_HIGH ? button_in[i] : ~button_in[i].
- Synchroniser per channel: s1 <= x, s2 <= s1.
- Stability counter cnt (width $clog2(DB_CYCLES+1)):
  - if s1 != s2, cnt <= 0;
  - else if cnt < DB_CYCLES, cnt <= cnt+1;
  - else hold (saturates at DB_CYCLES, never wraps).
- Decision: when cnt == DB_CYCLES and s2 != DB_out, DB_out <= s2 and the matching press_pulse/release_pulse is 1 for that cycle only; otherwise DB_out holds and the pulses are 0.
- Long counter lcnt (width $clog2(LONG_CYCLES+1)):
  - while DB_out == 1 and lcnt < LONG_CYCLES, lcnt <= lcnt+1;
  - long_pulse is 1 on exactly the edge where lcnt becomes LONG_CYCLES, then lcnt saturates (no repeat);
  - when DB_out == 0, lcnt <= 0.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.
- A bounce that returns to the current DB_out level before the counter saturates produces no event. A glitch after saturation resets cnt but does not change DB_out.

## Timing
- Reset values: s1=s2=0, cnt=0, lcnt=0, DB_out=0, all pulses 0, any_active=0. These are normalised values, so with ACTIVE_HIGH=0 an idle-high pin produces no event after reset.
- Reset asserted mid-operation: on the next edge everything returns to its reset value. No release_pulse is emitted for a channel that was pressed.
- Press latency: the new level first sampled into s1 at edge E0, then held stable, makes DB_out change at edge E0+DB_CYCLES+2. The pulse is high in the cycle following that edge.
- Minimum accepted pulse width at the pin is DB_CYCLES+2 cycles; anything shorter is rejected.
- long_pulse is asserted exactly LONG_CYCLES cycles after press_pulse.
- Releasing in the same cycle lcnt would saturate: release wins, with no long_pulse. lcnt clears the edge after DB_out falls.
- press_pulse and release_pulse are never both 1 on one channel. long_pulse never coincides with press_pulse.
- All outputs are registered; there is no combinational path from button_in to any output.

## Test plan
- Reset/idle: CH=4, DB_CYCLES=8, ACTIVE_HIGH=0, pins held 1, reset pulsed -> DB_out=0, no pulses for 100 cycles.
- Clean press/release: ch0 goes 1 at E0 and is held 30 cycles -> DB_out[0]=1 and press_pulse[0] for one cycle after edge E0+10; the release mirrors this with release_pulse[0] 10 cycles after the pin falls.
- Bounce rejection: ch1 toggles every 3 cycles for 40 cycles, then settles to 1 -> no events during bouncing; press_pulse[1] comes 10 cycles after the last toggle. A 9-cycle-wide pulse produces nothing.
- Long press: LONG_CYCLES=20, ch2 held 60 cycles -> long_pulse[2] once, 20 cycles after press_pulse[2]. Releasing at lcnt=19 gives no long_pulse.
- Simultaneous channels: ch0 and ch3 pressed on the same edge -> press_pulse=4'b1001 in one cycle, any_active=1 concurrently.
- Reset mid-press: ch2 debounced-pressed, reset asserted for 1 cycle -> all outputs 0 next cycle with no release_pulse. While the pin stays pressed, press_pulse re-fires 10 cycles after reset deasserts.
